// File: rtl/raycast_sequencer.sv
// Streams walls through rayCast for one ray and keeps the nearest hit; one wall per cycle.
// Result valid N+2 cycles after accept (1 for N=0); result held until res_ready, requests ignored meanwhile.
module raycast_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic signed [15:0]       req_x1,
  input  logic signed [15:0]       req_y1,
  input  logic signed [15:0]       req_x2,
  input  logic signed [15:0]       req_y2,
  input  logic        [ADDR_W:0]   num_walls,
  output logic        [ADDR_W-1:0] wall_addr,
  input  logic        [63:0]       wall_data,
  output logic signed [15:0]       rc_x1,
  output logic signed [15:0]       rc_y1,
  output logic signed [15:0]       rc_x2,
  output logic signed [15:0]       rc_y2,
  output logic signed [15:0]       rc_x3,
  output logic signed [15:0]       rc_y3,
  output logic signed [15:0]       rc_x4,
  output logic signed [15:0]       rc_y4,
  input  logic                     rc_intersection,
  input  logic        [15:0]       rc_ray_distance,
  input  logic        [7:0]        rc_uv_x,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_hit,
  output logic        [15:0]       res_distance,
  output logic        [7:0]        res_uv_x,
  output logic        [ADDR_W-1:0] res_wall
);

  localparam logic [ADDR_W:0] MAX_WALLS = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      res_valid_q, res_valid_d;
  logic        [ADDR_W-1:0]  addr_q, addr_d;
  logic        [ADDR_W-1:0]  last_q, last_d;
  logic                      data_vld_q, data_vld_d;
  logic        [ADDR_W-1:0]  eval_idx_q, eval_idx_d;
  logic signed [15:0]        ray_x1_q, ray_x1_d, ray_y1_q, ray_y1_d;
  logic signed [15:0]        ray_x2_q, ray_x2_d, ray_y2_q, ray_y2_d;
  logic                      best_hit_q, best_hit_d;
  logic        [15:0]        best_dist_q, best_dist_d;
  logic        [7:0]         best_uv_q, best_uv_d;
  logic        [ADDR_W-1:0]  best_wall_q, best_wall_d;
  logic        [ADDR_W:0]    n_clamped;
  logic                      better;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_d      = last_q;
    ray_x1_d    = ray_x1_q;
    ray_y1_d    = ray_y1_q;
    ray_x2_d    = ray_x2_q;
    ray_y2_d    = ray_y2_q;
    best_hit_d  = best_hit_q;
    best_dist_d = best_dist_q;
    best_uv_d   = best_uv_q;
    best_wall_d = best_wall_q;
    n_clamped   = (num_walls > MAX_WALLS) ? MAX_WALLS : num_walls;
    data_vld_d  = (state_q == SCAN);
    eval_idx_d  = addr_q;

    // First intersection always wins, even at distance FFFF; ties keep the earlier wall.
    better = data_vld_q && rc_intersection &&
             (!best_hit_q || (rc_ray_distance < best_dist_q));
    if (better) begin
      best_hit_d  = 1'b1;
      best_dist_d = rc_ray_distance;
      best_uv_d   = rc_uv_x;
      best_wall_d = eval_idx_q;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          ray_x1_d    = req_x1;
          ray_y1_d    = req_y1;
          ray_x2_d    = req_x2;
          ray_y2_d    = req_y2;
          last_d      = ADDR_W'(n_clamped - 1'b1);
          addr_d      = '0;
          best_hit_d  = 1'b0;
          best_dist_d = 16'hFFFF;
          best_uv_d   = '0;
          best_wall_d = '0;
          state_d     = (n_clamped == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (addr_q == last_q) state_d = DRAIN;
        else                  addr_d  = addr_q + 1'b1;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (res_valid_q && res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    res_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      addr_q      <= '0;
      last_q      <= '0;
      data_vld_q  <= 1'b0;
      eval_idx_q  <= '0;
      ray_x1_q    <= '0;
      ray_y1_q    <= '0;
      ray_x2_q    <= '0;
      ray_y2_q    <= '0;
      best_hit_q  <= 1'b0;
      best_dist_q <= 16'hFFFF;
      best_uv_q   <= '0;
      best_wall_q <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      addr_q      <= addr_d;
      last_q      <= last_d;
      data_vld_q  <= data_vld_d;
      eval_idx_q  <= eval_idx_d;
      ray_x1_q    <= ray_x1_d;
      ray_y1_q    <= ray_y1_d;
      ray_x2_q    <= ray_x2_d;
      ray_y2_q    <= ray_y2_d;
      best_hit_q  <= best_hit_d;
      best_dist_q <= best_dist_d;
      best_uv_q   <= best_uv_d;
      best_wall_q <= best_wall_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign res_valid    = res_valid_q;
  assign wall_addr    = addr_q;
  assign rc_x1        = ray_x1_q;
  assign rc_y1        = ray_y1_q;
  assign rc_x2        = ray_x2_q;
  assign rc_y2        = ray_y2_q;
  assign rc_x3        = wall_data[63:48];
  assign rc_y3        = wall_data[47:32];
  assign rc_x4        = wall_data[31:16];
  assign rc_y4        = wall_data[15:0];
  assign res_hit      = best_hit_q;
  assign res_distance = best_dist_q;
  assign res_uv_x     = best_uv_q;
  assign res_wall     = best_wall_q;

endmodule

// File: tb/tb_raycast_sequencer.sv
// Random and directed rays against a wall memory and rayCast model; a monitor
// compares every presented result and the address stream with a scoreboard.
module tb_raycast_sequencer;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic signed [15:0] req_x1 = '0, req_y1 = '0, req_x2 = '0, req_y2 = '0;
  logic        [6:0]  num_walls = '0;
  logic        [5:0]  wall_addr;
  logic        [63:0] wall_data = '0;
  logic signed [15:0] rc_x1, rc_y1, rc_x2, rc_y2, rc_x3, rc_y3, rc_x4, rc_y4;
  logic               rc_intersection;
  logic        [15:0] rc_ray_distance;
  logic        [7:0]  rc_uv_x;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic               res_hit;
  logic        [15:0] res_distance;
  logic        [7:0]  res_uv_x;
  logic        [5:0]  res_wall;

  typedef struct packed {
    logic        hit;
    logic [15:0] d;
    logic [7:0]  uv;
  } rc_t;

  typedef struct {
    logic        hit;
    logic [15:0] d;
    logic [7:0]  uv;
    logic [5:0]  w;
    int          n;
    int          acc;
    bit          seen;
  } exp_t;

  logic [63:0] mem [64];
  exp_t        sb [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          hold_cnt = 0;
  rc_t         rc_r;

  raycast_sequencer #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2),
    .num_walls(num_walls), .wall_addr(wall_addr), .wall_data(wall_data),
    .rc_x1(rc_x1), .rc_y1(rc_y1), .rc_x2(rc_x2), .rc_y2(rc_y2),
    .rc_x3(rc_x3), .rc_y3(rc_y3), .rc_x4(rc_x4), .rc_y4(rc_y4),
    .rc_intersection(rc_intersection), .rc_ray_distance(rc_ray_distance), .rc_uv_x(rc_uv_x),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_distance(res_distance), .res_uv_x(res_uv_x), .res_wall(res_wall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) wall_data <= mem[wall_addr];

  // Line/segment intersection: distance = t*1024 saturated, uv = u*255; junk outputs when missing.
  function automatic rc_t rc_fn(input logic signed [15:0] x1, y1, x2, y2, x3, y3, x4, y4);
    longint ax1, ay1, ax2, ay2, ax3, ay3, ax4, ay4, den, tn, un, dd;
    rc_t r;
    ax1 = x1; ay1 = y1; ax2 = x2; ay2 = y2; ax3 = x3; ay3 = y3; ax4 = x4; ay4 = y4;
    den = (ax1 - ax2) * (ay3 - ay4) - (ay1 - ay2) * (ax3 - ax4);
    tn  = (ax1 - ax3) * (ay3 - ay4) - (ay1 - ay3) * (ax3 - ax4);
    un  = (ay1 - ay2) * (ax1 - ax3) - (ax1 - ax2) * (ay1 - ay3);
    if (den < 0) begin den = -den; tn = -tn; un = -un; end
    r.hit = (den != 0) && (tn > 0) && (un >= 0) && (un <= den);
    if (r.hit) begin
      dd   = tn * 1024 / den;
      r.d  = (dd > 65535) ? 16'hFFFF : 16'(dd);
      r.uv = 8'(un * 255 / den);
    end else begin
      r.d  = 16'h0001;
      r.uv = 8'hAA;
    end
    return r;
  endfunction

  assign rc_r            = rc_fn(rc_x1, rc_y1, rc_x2, rc_y2, rc_x3, rc_y3, rc_x4, rc_y4);
  assign rc_intersection = rc_r.hit;
  assign rc_ray_distance = rc_r.d;
  assign rc_uv_x         = rc_r.uv;

  // Smallest hit distance over the first min(N,64) walls, then the lowest wall holding it.
  function automatic exp_t model(input logic signed [15:0] x1, y1, x2, y2, input int nw);
    exp_t e;
    rc_t  r;
    int   n, mind;
    n    = (nw > 64) ? 64 : nw;
    mind = 70000;
    for (int k = 0; k < n; k++) begin
      r = rc_fn(x1, y1, x2, y2, mem[k][63:48], mem[k][47:32], mem[k][31:16], mem[k][15:0]);
      if (r.hit && int'(r.d) < mind) mind = int'(r.d);
    end
    e.hit = 1'b0; e.d = 16'hFFFF; e.uv = 8'h00; e.w = 6'd0;
    for (int k = n - 1; k >= 0; k--) begin
      r = rc_fn(x1, y1, x2, y2, mem[k][63:48], mem[k][47:32], mem[k][31:16], mem[k][15:0]);
      if (r.hit && int'(r.d) == mind) begin
        e.hit = 1'b1; e.d = r.d; e.uv = r.uv; e.w = 6'(k);
      end
    end
    e.n = n; e.acc = 0; e.seen = 1'b0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_hit", 32'(res_hit), 32'd0);
    chk("rst_res_distance", 32'(res_distance), 32'hFFFF);
    chk("rst_res_uv_x", 32'(res_uv_x), 32'd0);
    chk("rst_res_wall", 32'(res_wall), 32'd0);
    chk("rst_wall_addr", 32'(wall_addr), 32'd0);
    chk("rst_rc_x1", 32'(rc_x1), 32'd0);
    chk("rst_rc_y2", 32'(rc_y2), 32'd0);
  endtask

  function automatic logic signed [15:0] rnd(input int span);
    int v;
    v = int'($urandom_range(0, 2 * span)) - span;
    return 16'(v);
  endfunction

  task automatic set_wall(input int k, input logic signed [15:0] x3, y3, x4, y4);
    mem[k] = {x3, y3, x4, y4};
  endtask

  task automatic rand_walls(input int n);
    for (int k = 0; k < n; k++) set_wall(k, rnd(1000), rnd(1000), rnd(1000), rnd(1000));
  endtask

  // Issue one ray; keeps garbage on req_* while busy. abort_at>=0 resets when wall_addr reaches it.
  task automatic run_ray(input logic signed [15:0] x1, y1, x2, y2, input int nw, input int abort_at);
    exp_t e;
    int   t;
    e = model(x1, y1, x2, y2, nw);
    @(negedge clk); #1;
    req_x1 = x1; req_y1 = y1; req_x2 = x2; req_y2 = y2;
    num_walls = 7'(nw);
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); #1; t++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    e.acc = cyc + 1;
    sb.push_back(e);
    t = 0;
    forever begin
      @(negedge clk); #1; t++;
      if (abort_at >= 0 && wall_addr == 6'(abort_at)) begin
        reset = 1'b1;
        req_valid = 1'b0;
        sb.delete();
        @(negedge clk); #1;
        check_reset_vals();
        reset = 1'b0;
        return;
      end
      if (res_valid && res_ready) begin
        req_valid = 1'b0;
        @(negedge clk);
        return;
      end
      if (t > 400) begin
        chk("result_timeout", 32'(res_valid), 32'd1);
        req_valid = 1'b0;
        sb.delete();
        return;
      end
      req_valid = 1'($urandom);
      req_x1 = rnd(500); req_y2 = rnd(500);
      num_walls = 7'($urandom);
    end
  endtask

  // Monitor: drives res_ready, compares presented results and address stream with the scoreboard front.
  initial begin
    exp_t e;
    int   due, ea;
    forever begin
      @(negedge clk);
      if (hold_cnt > 0 && res_valid) begin
        res_ready = 1'b0;
        hold_cnt--;
      end else begin
        res_ready = ($urandom_range(0, 3) != 0);
      end
      if (!reset) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", 32'(res_valid), 32'd0);
        end else begin
          e   = sb[0];
          due = e.acc + ((e.n == 0) ? 1 : e.n + 2);
          if (cyc >= e.acc) begin
            ea = (e.n == 0) ? 0 : (((cyc - e.acc) < e.n - 1) ? (cyc - e.acc) : e.n - 1);
            chk("wall_addr_seq", 32'(wall_addr), 32'(ea));
          end
          if (res_valid) begin
            if (!e.seen) begin
              chk("res_valid_latency", 32'(cyc), 32'(due));
              sb[0].seen = 1'b1;
            end
            chk("res_hit", 32'(res_hit), 32'(e.hit));
            chk("res_distance", 32'(res_distance), 32'(e.d));
            chk("res_uv_x", 32'(res_uv_x), 32'(e.uv));
            chk("res_wall", 32'(res_wall), 32'(e.w));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (res_ready) void'(sb.pop_front());
          end else if (cyc >= due) begin
            chk("res_valid_late", 32'(res_valid), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals();
    reset = 1'b0;

    run_ray(0, 0, 100, 0, 0, -1);

    set_wall(0, 50, -10, 50, 10);
    run_ray(0, 0, 100, 0, 1, -1);

    set_wall(0, 300, -10, 300, 10);
    set_wall(1, 100, -10, 100, 10);
    set_wall(2, 200, -10, 200, 10);
    run_ray(0, 0, 400, 0, 3, -1);

    for (int k = 0; k < 8; k++) set_wall(k, -50, -10, -50, 10);
    set_wall(2, 200, -10, 200, 10);
    set_wall(5, 200, -30, 200, 10);
    run_ray(0, 0, 400, 0, 8, -1);

    set_wall(0, 100, -10, 100, 10);
    set_wall(1, 100, -20, 100, 10);
    run_ray(0, 0, 1, 0, 2, -1);

    set_wall(0, 300, -10, 300, 10);
    set_wall(1, 100, -10, 100, 10);
    set_wall(2, 200, -10, 200, 10);
    hold_cnt = 10;
    run_ray(0, 0, 400, 0, 3, -1);

    rand_walls(16);
    run_ray(rnd(100), rnd(100), rnd(2000), rnd(2000), 16, 3);
    run_ray(rnd(100), rnd(100), rnd(2000), rnd(2000), 16, -1);

    rand_walls(64);
    run_ray(rnd(100), rnd(100), rnd(2000), rnd(2000), 100, -1);
    run_ray(rnd(100), rnd(100), rnd(2000), rnd(2000), 64, -1);

    for (int i = 0; i < 25; i++) begin
      int n;
      n = $urandom_range(0, 20);
      rand_walls(n);
      run_ray(rnd(200), rnd(200), rnd(2000), rnd(2000), n, -1);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raycast_sequencer.md
# raycast_sequencer

Drives the combinational `rayCast` intersection unit for one ray at a time. It accepts a ray request, streams every wall segment from the wall memory through `rayCast`, and keeps the nearest hit. It returns one result (hit flag, distance, texture column, wall index) per ray to the column renderer. It sits between the column renderer and `rayCast`/wall memory, on the initiator side of the `rayCast` interface.

## Interface
- `ADDR_W`, 6: wall memory address width; at most 2^ADDR_W walls.
- `clk` in 1: clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: ray request valid.
- `req_ready` out 1: block idle, can accept a request.
- `req_x1`, `req_y1`, `req_x2`, `req_y2` in 16 each, signed: ray origin and ray direction point.
- `num_walls` in ADDR_W+1: wall count N, sampled on accept.
- `wall_addr` out ADDR_W: registered wall memory read address.
- `wall_data` in 64: synchronous-read memory word, valid one cycle after `wall_addr`. Packing is [63:48] x3, [47:32] y3, [31:16] x4, [15:0] y4.
- `rc_x1`..`rc_y2` out 16 each: registered ray to `rayCast`.
- `rc_x3`..`rc_y4` out 16 each: combinational fields of `wall_data` to `rayCast`.
- `rc_intersection` in 1, `rc_ray_distance` in 16 unsigned, `rc_uv_x` in 8: `rayCast` results, combinational on `rc_*` outputs.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_hit` out 1: at least one wall intersected.
- `res_distance` out 16: nearest distance; 16'hFFFF when no hit.
- `res_uv_x` out 8: uv_x of nearest wall; 0 when no hit.
- `res_wall` out ADDR_W: index of nearest wall; 0 when no hit.

## Operation
- States are IDLE, SCAN, DRAIN, DONE. `req_ready`=1 only in IDLE. `res_valid`=1 only in DONE.
- **IDLE**: on `req_valid`, latch the ray into `rc_x1..rc_y2` and latch N.
  - Reset best registers: hit=0, dist=FFFF, uv=0, wall=0.
  - Set `wall_addr`=0.
  - Next state is SCAN if N≥1, else DONE.
- **SCAN**: `wall_addr` increments every cycle until it reaches N-1.
  - Internal `data_valid` flag is a one-cycle-delayed copy of "address issued". `eval_idx` is a one-cycle-delayed copy of `wall_addr`.
  - Go to DRAIN in the cycle after address N-1 is issued.
- **Compare** (SCAN and DRAIN, whenever `data_valid`=1): if `rc_intersection`=1 and `rc_ray_distance` < best dist (strict, unsigned):
  - dist ← `rc_ray_distance`
  - uv ← `rc_uv_x`
  - wall ← `eval_idx`
  - hit ← 1
  - Equal distances therefore keep the lower wall index. Distance FFFF with intersection still sets hit=1 if hit was 0.
- **DRAIN**: evaluate the last wall, then go to DONE.
- **DONE**: `res_*` show the best registers and hold stable while `res_ready`=0. On `res_valid`&`res_ready`, go to IDLE.
- `wall_addr` holds its last value outside SCAN. `rc_x1..rc_y2` hold until the next accept.
- `req_*` changes outside IDLE are ignored. `num_walls` > 2^ADDR_W is clamped to 2^ADDR_W.
- **Reset** (any state, including mid-scan or DONE): IDLE, current ray discarded, no result emitted. Reset values:
  - `req_ready`=1 (first cycle after reset)
  - `res_valid`=0, `res_hit`=0, `res_distance`=FFFF, `res_uv_x`=0, `res_wall`=0
  - `wall_addr`=0, `rc_x1..rc_y2`=0

## Timing
- Accept edge is A (`req_valid`&`req_ready` high at edge A).
- Address k is presented during cycle A+k, for k=0..N-1.
- Wall k is compared at edge A+k+2.
- `res_valid` rises at edge A+N+2 for N≥1, and at edge A+1 for N=0.
- Throughput is one wall per cycle. Per-ray occupancy is N+3 cycles plus any `res_ready` stall.
- Earliest next accept is the edge after the result handshake edge. `req_ready` rises at the handshake edge.

## Test plan
- N=0, request accepted → `res_valid` one cycle later; hit=0, distance=FFFF, uv=0, wall=0.
- Ray (0,0)->(100,0), one wall (50,-10)-(50,10) → `res_valid` at A+3; hit=1; distance and uv_x equal the `rayCast` outputs for that wall; wall=0.
- Three walls at x=300, 100, 200 crossing ray (0,0)->(400,0) → wall=1, with the x=100 distance; `wall_addr` sequence 0,1,2 on consecutive cycles; `res_valid` at A+5.
- Two walls at identical distance (indices 2 and 5) with non-hitting walls elsewhere, N=8 → wall=2.
- Hold `res_ready`=0 for 10 cycles in DONE → outputs stable, `req_ready`=0, `req_valid` ignored; handshake then returns to IDLE.
- Assert `reset` mid-SCAN at wall 3 of N=16 → next cycle IDLE, `req_ready`=1, `res_valid`=0, all outputs at reset values; a new request completes normally.
